// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache sequencer: state encoding,
// default line size and the width/saturation helper of the optional counters.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int CNT_W           = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dcache_refill_cnt.sv
// Word counter for a line refill: advances on each accepted word, flags the
// last word of the line and wraps to zero after it.
module dcache_refill_cnt
    import dcache_pkg::*;
#(
    parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int WI_W        = $clog2(BLOCK_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_inc,
    output logic [WI_W-1:0] o_cnt,
    output logic            o_last
);

    logic [WI_W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == WI_W'(BLOCK_WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_last ? '0 : r_cnt + WI_W'(1);
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache sequencer (write-through, write-no-allocate, blocking): line refill
// on read miss, word write-through on store. Optional counters: DCACHE_PERF_CNT_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int ADDR_W      = 10,
    parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int WI_W        = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hit,
    input  logic              mem_ready,
    output logic              stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              refill_we,
    output logic [WI_W-1:0]   refill_idx,
    output logic              tag_we,
    output logic              cache_we
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  rd_hit_cnt,
    output logic [CNT_W-1:0]  rd_miss_cnt,
    output logic [CNT_W-1:0]  wr_cnt
`endif
);

    state_e          r_state;
    logic [WI_W-1:0] w_word_cnt;
    logic            w_last;
    logic            w_inc;

    assign w_inc = (r_state == FILL) && mem_ready;

    dcache_refill_cnt #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_refill_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_inc),
        .o_cnt  (w_word_cnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (MemWrite)             r_state <= WRITE;
                    else if (MemRead && !hit) r_state <= FILL;
                end
                FILL:    if (mem_ready && w_last) r_state <= DONE;
                DONE:    r_state <= IDLE;
                WRITE:   if (mem_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and the live core strobes: the stall must rise
    // in the very cycle a miss or store is seen, so they cannot be registered.
    // NOTE: every output gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        refill_we  = 1'b0;
        refill_idx = '0;
        tag_we     = 1'b0;
        cache_we   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (MemWrite) begin
                    stall    = 1'b1;
                    cache_we = hit;
                end else if (MemRead && !hit) begin
                    stall = 1'b1;
                end
            end
            FILL: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {addr[ADDR_W-1:WI_W], w_word_cnt};
                refill_idx = w_word_cnt;
                refill_we  = mem_ready;
                tag_we     = mem_ready && w_last;
            end
            DONE: stall = 1'b1;
            WRITE: begin
                stall      = !mem_ready;
                mem_wr_req = 1'b1;
                mem_addr   = addr;
            end
            default: stall = 1'b0;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic             r_replay;
    logic [CNT_W-1:0] r_rd_hit_cnt;
    logic [CNT_W-1:0] r_rd_miss_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             w_rd_hit;
    logic             w_rd_miss;
    logic             w_wr;

    // The load replayed after a refill is the same access as the miss.
    assign w_rd_hit  = (r_state == IDLE) && !MemWrite && MemRead && hit && !r_replay;
    assign w_rd_miss = (r_state == IDLE) && !MemWrite && MemRead && !hit;
    assign w_wr      = (r_state == IDLE) && MemWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_replay      <= 1'b0;
            r_rd_hit_cnt  <= '0;
            r_rd_miss_cnt <= '0;
            r_wr_cnt      <= '0;
        end else begin
            r_replay <= (r_state == DONE);
            if (w_rd_hit)  r_rd_hit_cnt  <= sat_inc(r_rd_hit_cnt);
            if (w_rd_miss) r_rd_miss_cnt <= sat_inc(r_rd_miss_cnt);
            if (w_wr)      r_wr_cnt      <= sat_inc(r_wr_cnt);
        end
    end

    assign rd_hit_cnt  = r_rd_hit_cnt;
    assign rd_miss_cnt = r_rd_miss_cnt;
    assign wr_cnt      = r_wr_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed cases plus randomized accesses
// against a transaction-level model of the refill / write-through protocol.
module tb_dcache_ctrl;

    localparam int ADDR_W = 10;
    localparam int BW     = 4;
    localparam int WI_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              mem_ready;
    logic              stall;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              refill_we;
    logic [WI_W-1:0]   refill_idx;
    logic              tag_we;
    logic              cache_we;
`ifdef DCACHE_PERF_CNT_EN
    logic [15:0]       rd_hit_cnt;
    logic [15:0]       rd_miss_cnt;
    logic [15:0]       wr_cnt;
    int                m_hits, m_misses, m_writes;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(
        .ADDR_W      (ADDR_W),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .addr        (addr),
        .hit         (hit),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .refill_we   (refill_we),
        .refill_idx  (refill_idx),
        .tag_we      (tag_we),
        .cache_we    (cache_we)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .rd_hit_cnt  (rd_hit_cnt),
        .rd_miss_cnt (rd_miss_cnt),
        .wr_cnt      (wr_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef DCACHE_PERF_CNT_EN
    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic check_counters(input string tag);
        @(negedge clk);
        check({tag, "_hits"},   rd_hit_cnt,  m_hits);
        check({tag, "_misses"}, rd_miss_cnt, m_misses);
        check({tag, "_writes"}, wr_cnt,      m_writes);
    endtask
`endif

    task automatic do_idle();
        MemRead = 0; MemWrite = 0; mem_ready = 0;
        @(negedge clk);
        check("idle_outs", {stall, mem_rd_req, mem_wr_req, refill_we, tag_we, cache_we}, 0);
        check("idle_addr", mem_addr, 0);
        tick();
    endtask

    // One load: a hit retires at once; a miss refills the whole aligned line,
    // each word answered by memory after lat cycles, then the load replays.
    task automatic do_read(input logic [ADDR_W-1:0] a, input bit h, input int lat);
        int words, wt, stalls, tags, cyc;
        MemRead = 1; MemWrite = 0; addr = a; hit = h; mem_ready = 0;
        @(negedge clk);
        check("rd_first_stall", stall, !h);
        check("rd_first_quiet", {mem_rd_req, mem_wr_req, cache_we, tag_we, refill_we}, 0);
`ifdef DCACHE_PERF_CNT_EN
        if (h) m_hits = sat(m_hits); else m_misses = sat(m_misses);
`endif
        tick();
        if (!h) begin
            words = 0; wt = 0; stalls = 0; tags = 0; cyc = 0;
            while (cyc < 200) begin
                mem_ready = (wt == lat - 1);
                @(negedge clk);
                if (!stall) break;
                stalls++;
                if (mem_rd_req) begin
                    check("fill_addr", mem_addr, (int'(a) / BW) * BW + words);
                    check("fill_idx",  refill_idx, words);
                    check("fill_we",   refill_we, mem_ready);
                    check("fill_tag",  tag_we, mem_ready && (words == BW - 1));
                    if (mem_ready) begin words++; wt = 0; end
                    else wt++;
                end else begin
                    check("done_quiet", {refill_we, tag_we}, 0);
                end
                check("fill_no_wr", {mem_wr_req, cache_we}, 0);
                if (tag_we) tags++;
                tick();
                if (tags > 0) hit = 1;
                cyc++;
            end
            if (cyc >= 200) check("miss_timeout", 0, 1);
            check("miss_penalty", stalls, BW * lat + 1);
            check("miss_words",   words, BW);
            check("miss_tag_cnt", tags, 1);
            check("replay_quiet", {mem_rd_req, mem_wr_req, refill_we, tag_we, cache_we}, 0);
            tick();
        end
        MemRead = 0; mem_ready = 0;
    endtask

    // One store: the cache is updated only on hit, memory is always written.
    task automatic do_write(input logic [ADDR_W-1:0] a, input bit h, input int lat,
                            input bit also_read);
        MemWrite = 1; MemRead = also_read; addr = a; hit = h; mem_ready = 0;
        @(negedge clk);
        check("wr_first_stall", stall, 1);
        check("wr_cache_we",    cache_we, h);
        check("wr_first_quiet", {mem_rd_req, mem_wr_req, tag_we, refill_we}, 0);
`ifdef DCACHE_PERF_CNT_EN
        m_writes = sat(m_writes);
`endif
        tick();
        for (int w = 0; w < lat; w++) begin
            mem_ready = (w == lat - 1);
            @(negedge clk);
            check("wr_req",   mem_wr_req, 1);
            check("wr_addr",  mem_addr, a);
            check("wr_stall", stall, !mem_ready);
            check("wr_quiet", {cache_we, tag_we, mem_rd_req, refill_we}, 0);
            tick();
        end
        MemWrite = 0; MemRead = 0; mem_ready = 0;
    endtask

    task automatic apply_reset();
        MemRead = 0; MemWrite = 0; hit = 0; mem_ready = 0; addr = '0;
        rst_n = 0;
        #1;
        check("rst_outs", {stall, mem_rd_req, mem_wr_req, refill_we, tag_we, cache_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_idx",  refill_idx, 0);
        tick();
        rst_n = 1;
`ifdef DCACHE_PERF_CNT_EN
        m_hits = 0; m_misses = 0; m_writes = 0;
`endif
    endtask

    initial begin
        rst_n = 0; MemRead = 0; MemWrite = 0; hit = 0; mem_ready = 0; addr = '0;
        #3;
        apply_reset();
        do_idle();

        // Directed protocol cases.
        do_read(10'h024, 1'b1, 1);
        do_read(10'h026, 1'b0, 1);
        do_read(10'h1A5, 1'b0, 3);
        do_write(10'h100, 1'b1, 2, 1'b0);
        do_write(10'h100, 1'b0, 3, 1'b0);
        do_write(10'h2C3, 1'b0, 1, 1'b1);
        do_idle();

        // Reset abandons a refill at word 2; the next miss restarts at word 0.
        MemRead = 1; MemWrite = 0; addr = 10'h0B3; hit = 0; mem_ready = 0;
        tick();
        mem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("prerst_tag", tag_we, 0);
            tick();
        end
        mem_ready = 0;
        @(negedge clk);
        check("prerst_idx", refill_idx, 2);
        check("prerst_req", mem_rd_req, 1);
        #1;
        rst_n = 0; MemRead = 0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_req",   mem_rd_req, 0);
        check("midrst_tag",   tag_we, 0);
        tick();
        check("rst_hold_quiet", {stall, mem_rd_req, tag_we, refill_we}, 0);
        rst_n = 1;
`ifdef DCACHE_PERF_CNT_EN
        m_hits = 0; m_misses = 0; m_writes = 0;
`endif
        do_idle();
        do_read(10'h0B3, 1'b0, 1);

        // Randomized access stream.
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [ADDR_W-1:0] a;
            op = $urandom_range(0, 9);
            a  = ADDR_W'($urandom_range(0, 1023));
            case (op)
                0, 1:       do_idle();
                2, 3, 4, 5: do_read(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
                6, 7, 8:    do_write(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0);
                default:    do_write(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
            endcase
        end
        do_idle();

`ifdef DCACHE_PERF_CNT_EN
        check_counters("rand_cnt");
        tick();
        apply_reset();
        do_read(10'h010, 1'b1, 1);
        do_read(10'h011, 1'b1, 1);
        do_read(10'h012, 1'b0, 2);
        do_read(10'h200, 1'b0, 1);
        do_read(10'h013, 1'b1, 1);
        do_write(10'h100, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("mix_hits",   rd_hit_cnt,  3);
        check("mix_misses", rd_miss_cnt, 2);
        check("mix_writes", wr_cnt,      1);
        tick();
        // Back-to-back hits drive the hit counter into saturation.
        MemRead = 1; MemWrite = 0; hit = 1; addr = 10'h024;
        for (int i = 0; i < 65540; i++) begin
            m_hits = sat(m_hits);
            tick();
        end
        MemRead = 0;
        check_counters("sat_cnt");
        check("sat_value", rd_hit_cnt, 16'hFFFF);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
